// File: rtl/exec_core_alu_rf_tb.sv
// ----------------------------------------------------------------------------
// exec_core_alu_rf_tb
// Execution-core slice of a SPARC-subset datapath. Three independent parts:
//   - 4-window SPARC register file (72 x 32), async reads, clocked write
//   - combinational 32-bit ALU with N/Z/V/C condition codes
//   - trap-base adder stepping the TBR-derived trap vector by 4
//
// Ports
//   Clk, Clr        clock (writes on rising edge), async active-low clear
//   RA, RB          read addresses (r0-r31)      -> Aout, Bout
//   RC, Rin, RFE    write address, data, active-low write enable
//   CWP             current window pointer
//   A_in, B_in      ALU operands
//   opcode, carry   SPARC op3 and carry-in for ADDX/SUBX
//   result, N/Z/V/C ALU result and condition codes
//   x, TB_ADD       trap-base input and active-low add enable -> tb_out
// ----------------------------------------------------------------------------
module exec_core_alu_rf_tb (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [4:0]  RA,
    input  logic [4:0]  RB,
    input  logic [4:0]  RC,
    input  logic [1:0]  CWP,
    input  logic [31:0] Rin,
    input  logic        RFE,
    output logic [31:0] Aout,
    output logic [31:0] Bout,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic [5:0]  opcode,
    input  logic        carry,
    output logic [31:0] result,
    output logic        N,
    output logic        Z,
    output logic        V,
    output logic        C,
    input  logic [31:0] x,
    input  logic        TB_ADD,
    output logic [31:0] tb_out
);

    // Physical slots 0-7 are the globals; 8-71 are a 64-entry ring shared by
    // the four windows. Each window advances by 16, so the ins (r24-31) of
    // window w land on the outs (r8-15) of window w+1, wrapping mod 64.
    function automatic logic [6:0] phys_idx(input logic [4:0] r, input logic [1:0] w);
        logic [5:0] ofs;
        if (r < 5'd8) begin
            return {2'b00, r};
        end
        ofs = ({1'b0, r} - 6'd8) + {w, 4'b0000};
        return 7'd8 + {1'b0, ofs};
    endfunction

    logic [31:0] regs [0:71];

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < 72; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (!RFE && (RC != 5'd0)) begin
            regs[phys_idx(RC, CWP)] <= Rin;
        end
    end

    // r0 is hard-wired; slot 0 is never written anyway, but forcing the read
    // keeps r0 independent of storage.
    assign Aout = (RA == 5'd0) ? 32'h0 : regs[phys_idx(RA, CWP)];
    assign Bout = (RB == 5'd0) ? 32'h0 : regs[phys_idx(RB, CWP)];

    // ------------------------------------------------------------------ ALU
    logic [32:0] sum_ext;
    logic [32:0] diff_ext;
    logic        cin;

    always_comb begin
        result   = B_in;
        V        = 1'b0;
        C        = 1'b0;
        cin      = 1'b0;
        sum_ext  = 33'h0;
        diff_ext = 33'h0;
        if (!opcode[5]) begin
            // opcode[4] selects the cc-form, which computes the same thing
            unique case (opcode[3:0])
                4'h0, 4'h8: begin
                    cin     = (opcode[3:0] == 4'h8) ? carry : 1'b0;
                    sum_ext = {1'b0, A_in} + {1'b0, B_in} + {32'h0, cin};
                    result  = sum_ext[31:0];
                    C       = sum_ext[32];
                    V       = (A_in[31] == B_in[31]) && (result[31] != A_in[31]);
                end
                4'h4, 4'hC: begin
                    cin      = (opcode[3:0] == 4'hC) ? carry : 1'b0;
                    // bit 32 goes high exactly when A < B + cin (borrow)
                    diff_ext = {1'b0, A_in} - {1'b0, B_in} - {32'h0, cin};
                    result   = diff_ext[31:0];
                    C        = diff_ext[32];
                    V        = (A_in[31] != B_in[31]) && (result[31] != A_in[31]);
                end
                4'h1:    result = A_in & B_in;
                4'h2:    result = A_in | B_in;
                4'h3:    result = A_in ^ B_in;
                4'h5:    result = A_in & ~B_in;
                4'h6:    result = A_in | ~B_in;
                4'h7:    result = ~(A_in ^ B_in);
                default: result = B_in;
            endcase
        end else begin
            unique case (opcode)
                6'h25:   result = A_in << B_in[4:0];
                6'h26:   result = A_in >> B_in[4:0];
                6'h27:   result = $signed(A_in) >>> B_in[4:0];
                default: result = B_in;
            endcase
        end
    end

    assign N = result[31];
    assign Z = (result == 32'h0);

    // ----------------------------------------------------- trap-base adder
    assign tb_out = TB_ADD ? x : (x + 32'd4);

endmodule

// File: tb/tb_exec_core_alu_rf_tb.sv
module tb_exec_core_alu_rf_tb;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic [4:0]  RA = '0, RB = '0, RC = '0;
    logic [1:0]  CWP = '0;
    logic [31:0] Rin = '0;
    logic        RFE = 1'b1;
    logic [31:0] Aout, Bout;
    logic [31:0] A_in = '0, B_in = '0;
    logic [5:0]  opcode = '0;
    logic        carry = 1'b0;
    logic [31:0] result;
    logic        N, Z, V, C;
    logic [31:0] x = '0;
    logic        TB_ADD = 1'b1;
    logic [31:0] tb_out;

    int checks = 0;
    int failures = 0;

    exec_core_alu_rf_tb dut (
        .Clk(Clk), .Clr(Clr), .RA(RA), .RB(RB), .RC(RC), .CWP(CWP),
        .Rin(Rin), .RFE(RFE), .Aout(Aout), .Bout(Bout),
        .A_in(A_in), .B_in(B_in), .opcode(opcode), .carry(carry),
        .result(result), .N(N), .Z(Z), .V(V), .C(C),
        .x(x), .TB_ADD(TB_ADD), .tb_out(tb_out)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- register-file reference model (architectural view)
    logic [31:0] m_glob [8];
    logic [31:0] m_outs [4][8];
    logic [31:0] m_locs [4][8];

    function automatic logic [31:0] m_read(input int r, input int w);
        if (r == 0)  return 32'h0;
        if (r < 8)   return m_glob[r];
        if (r < 16)  return m_outs[w][r-8];
        if (r < 24)  return m_locs[w][r-16];
        return m_outs[(w+1)%4][r-24];
    endfunction

    task automatic m_write(input int r, input int w, input logic [31:0] d);
        if (r == 0)       return;
        else if (r < 8)   m_glob[r] = d;
        else if (r < 16)  m_outs[w][r-8] = d;
        else if (r < 24)  m_locs[w][r-16] = d;
        else              m_outs[(w+1)%4][r-24] = d;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 8; i++) begin
            m_glob[i] = 32'h0;
            for (int w = 0; w < 4; w++) begin
                m_outs[w][i] = 32'h0;
                m_locs[w][i] = 32'h0;
            end
        end
    endtask

    // ---------------- ALU reference model (wide arithmetic)
    task automatic alu_model(input logic [31:0] a, input logic [31:0] b,
                             input logic [5:0] op, input logic ci,
                             output logic [31:0] res, output logic [3:0] nzvc);
        int          base;
        longint      s;
        longint unsigned ua, ub;
        logic        v, c;
        ua = {32'h0, a};
        ub = {32'h0, b};
        v = 1'b0;
        c = 1'b0;
        base = -1;
        if (op < 6'h20 && ((op & 6'h0F) <= 6'h08 || (op & 6'h0F) == 6'h0C))
            base = int'(op & 6'h0F);
        case (base)
            0, 8: begin
                s   = longint'(base == 8 ? ci : 1'b0);
                res = 32'(ua + ub + longint'(unsigned'(s)));
                c   = (ua + ub + longint'(unsigned'(s))) > 64'hFFFF_FFFF;
                s   = longint'($signed(a)) + longint'($signed(b)) + s;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4, 12: begin
                s   = longint'(base == 12 ? ci : 1'b0);
                res = a - b - 32'(s);
                c   = ua < (ub + longint'(unsigned'(s)));
                s   = longint'($signed(a)) - longint'($signed(b)) - s;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: res = a & b;
            2: res = a | b;
            3: res = a ^ b;
            5: res = a & ~b;
            6: res = a | ~b;
            7: res = ~(a ^ b);
            default: begin
                if (op == 6'h25)      res = a << b[4:0];
                else if (op == 6'h26) res = a >> b[4:0];
                else if (op == 6'h27) res = $signed(a) >>> b[4:0];
                else                  res = b;
            end
        endcase
        nzvc = {res[31], res == 32'h0, v, c};
    endtask

    // ---------------- stimulus helpers (no checking)
    task automatic rf_write(input logic [4:0] rc, input logic [1:0] w,
                            input logic [31:0] d, input logic we_n);
        @(negedge Clk);
        RC = rc; CWP = w; Rin = d; RFE = we_n;
        @(posedge Clk);
        #1;
        RFE = 1'b1;
        if (!we_n && Clr) m_write(int'(rc), int'(w), d);
    endtask

    task automatic set_read(input logic [4:0] ra, input logic [4:0] rb, input logic [1:0] w);
        RA = ra; RB = rb; CWP = w;
        #1;
    endtask

    // ---------------- tests
    task automatic test_reset();
        logic [4:0] regs_l [3];
        regs_l[0] = 5'd0; regs_l[1] = 5'd5; regs_l[2] = 5'd17;
        m_clear();
        #12;
        @(negedge Clk);
        Clr = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 3; i++) begin
                set_read(regs_l[i], regs_l[i], 2'(w));
                checks++;
                if (Aout !== 32'h0 || Bout !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_read r%0d cwp%0d got A=%h B=%h exp 0", regs_l[i], w, Aout, Bout);
                end
            end
        end
        rf_write(5'd0, 2'd0, 32'hFFFF_FFFF, 1'b0);
        set_read(5'd0, 5'd0, 2'd0);
        checks++;
        if (Aout !== 32'h0) begin
            failures++;
            $display("FAIL r0_write got=%h exp=00000000", Aout);
        end
    endtask

    task automatic test_write_add();
        logic [31:0] ra_v, rb_v;
        rf_write(5'd17, 2'd0, 32'hA204_4012, 1'b0);
        rf_write(5'd18, 2'd0, 32'hA204_4012, 1'b0);
        set_read(5'd17, 5'd18, 2'd0);
        checks++;
        if (Aout !== 32'hA204_4012 || Bout !== 32'hA204_4012) begin
            failures++;
            $display("FAIL rf_readback got A=%h B=%h exp A204_4012", Aout, Bout);
        end
        ra_v = Aout; rb_v = Bout;
        A_in = ra_v; B_in = rb_v; opcode = 6'h10; carry = 1'b0;
        #1;
        checks++;
        if (result !== 32'h4408_8024 || {N, Z, V, C} !== 4'b0011) begin
            failures++;
            $display("FAIL add_flags got res=%h nzvc=%b exp res=44088024 nzvc=0011", result, {N, Z, V, C});
        end
        rf_write(5'd17, 2'd0, result, 1'b0);
        set_read(5'd17, 5'd18, 2'd0);
        checks++;
        if (Aout !== 32'h4408_8024) begin
            failures++;
            $display("FAIL writeback got=%h exp=44088024", Aout);
        end
    endtask

    task automatic test_window();
        rf_write(5'd24, 2'd1, 32'h1234_5678, 1'b0);
        set_read(5'd8, 5'd24, 2'd2);
        checks++;
        if (Aout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL overlap_w1_w2 got=%h exp=12345678", Aout);
        end
        rf_write(5'd24, 2'd3, 32'hCAFE_F00D, 1'b0);
        set_read(5'd8, 5'd24, 2'd0);
        checks++;
        if (Aout !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL wrap_w3_w0 got=%h exp=cafef00d", Aout);
        end
        rf_write(5'd3, 2'd2, 32'h0000_0333, 1'b0);
        for (int w = 0; w < 4; w++)
            rf_write(5'd20, 2'(w), 32'h1000_0000 + 32'(w), 1'b0);
        for (int w = 0; w < 4; w++) begin
            set_read(5'd3, 5'd20, 2'(w));
            checks++;
            if (Aout !== 32'h0000_0333 || Bout !== m_read(20, w) || Bout !== 32'h1000_0000 + 32'(w)) begin
                failures++;
                $display("FAIL global_local cwp%0d got g=%h l=%h exp g=00000333 l=%h", w, Aout, Bout, m_read(20, w));
            end
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic        cin;
        logic [31:0] res;
        logic [3:0]  nzvc;
    } vec_t;

    task automatic test_alu_directed();
        vec_t v [9];
        v[0] = '{32'd5,         32'd5,  6'h14, 1'b0, 32'h0,         4'b0100};
        v[1] = '{32'd0,         32'd1,  6'h14, 1'b0, 32'hFFFF_FFFF, 4'b1001};
        v[2] = '{32'd1,         32'd1,  6'h08, 1'b1, 32'd3,         4'b0000};
        v[3] = '{32'h8000_0000, 32'd4,  6'h27, 1'b0, 32'hF800_0000, 4'b1000};
        v[4] = '{32'd1,         32'd31, 6'h25, 1'b0, 32'h8000_0000, 4'b1000};
        v[5] = '{32'h8000_0000, 32'd4,  6'h26, 1'b0, 32'h0800_0000, 4'b0000};
        v[6] = '{32'd5,         32'd3,  6'h0C, 1'b1, 32'd1,         4'b0000};
        v[7] = '{32'hF0F0_FFFF, 32'h0F0F_00FF, 6'h05, 1'b0, 32'hF0F0_FF00, 4'b1000};
        v[8] = '{32'h1111_1111, 32'h0000_1234, 6'h09, 1'b1, 32'h0000_1234, 4'b0000};
        for (int i = 0; i < 9; i++) begin
            A_in = v[i].a; B_in = v[i].b; opcode = v[i].op; carry = v[i].cin;
            #1;
            checks++;
            if (result !== v[i].res || {N, Z, V, C} !== v[i].nzvc) begin
                failures++;
                $display("FAIL alu_dir%0d op=%h got res=%h nzvc=%b exp res=%h nzvc=%b",
                         i, v[i].op, result, {N, Z, V, C}, v[i].res, v[i].nzvc);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [5:0]  ops [15];
        logic [31:0] er;
        logic [3:0]  ef;
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h27};
        for (int i = 0; i < 400; i++) begin
            A_in  = $urandom;
            B_in  = $urandom;
            if (i % 8 == 0) B_in = A_in;
            carry = 1'($urandom);
            opcode = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 14)] : 6'($urandom_range(0, 63));
            #1;
            alu_model(A_in, B_in, opcode, carry, er, ef);
            checks++;
            if (result !== er || {N, Z, V, C} !== ef) begin
                failures++;
                $display("FAIL alu_rand op=%h a=%h b=%h c=%b got res=%h nzvc=%b exp res=%h nzvc=%b",
                         opcode, A_in, B_in, carry, result, {N, Z, V, C}, er, ef);
            end
        end
    endtask

    task automatic test_rf_random();
        logic [4:0]  rc, rb;
        logic [1:0]  w;
        logic [31:0] d;
        logic        we_n;
        for (int i = 0; i < 300; i++) begin
            rc = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            w  = 2'($urandom_range(0, 3));
            d  = $urandom;
            we_n = ($urandom_range(0, 3) == 0);
            @(negedge Clk);
            RC = rc; CWP = w; Rin = d; RFE = we_n; RA = rc; RB = rb;
            #1;
            checks++;
            if (Aout !== m_read(rc, w) || Bout !== m_read(rb, w)) begin
                failures++;
                $display("FAIL rf_pre r%0d cwp%0d got A=%h B=%h exp A=%h B=%h",
                         rc, w, Aout, Bout, m_read(rc, w), m_read(rb, w));
            end
            @(posedge Clk);
            #1;
            RFE = 1'b1;
            if (!we_n) m_write(rc, w, d);
            checks++;
            if (Aout !== m_read(rc, w) || Bout !== m_read(rb, w)) begin
                failures++;
                $display("FAIL rf_post r%0d cwp%0d we_n=%b got A=%h B=%h exp A=%h B=%h",
                         rc, w, we_n, Aout, Bout, m_read(rc, w), m_read(rb, w));
            end
        end
    endtask

    task automatic test_write_gating();
        rf_write(5'd9, 2'd1, 32'h5555_AAAA, 1'b0);
        rf_write(5'd9, 2'd1, 32'hDEAD_BEEF, 1'b1);
        set_read(5'd9, 5'd9, 2'd1);
        checks++;
        if (Aout !== 32'h5555_AAAA) begin
            failures++;
            $display("FAIL rfe_high got=%h exp=5555aaaa", Aout);
        end
        // asynchronous clear between edges
        rf_write(5'd2, 2'd0, 32'h0BAD_F00D, 1'b0);
        @(negedge Clk);
        #2;
        Clr = 1'b0;
        m_clear();
        #1;
        for (int w = 0; w < 4; w++) begin
            set_read(5'd2, 5'd9, 2'(w));
            checks++;
            if (Aout !== 32'h0 || Bout !== 32'h0) begin
                failures++;
                $display("FAIL clr_mid cwp%0d got A=%h B=%h exp 0", w, Aout, Bout);
            end
        end
        @(negedge Clk);
        Clr = 1'b1;
        // clear coincident with a write edge
        @(negedge Clk);
        RC = 5'd5; CWP = 2'd0; Rin = 32'h7777_7777; RFE = 1'b0;
        @(posedge Clk);
        Clr = 1'b0;
        #1;
        RFE = 1'b1;
        @(negedge Clk);
        Clr = 1'b1;
        set_read(5'd5, 5'd0, 2'd0);
        checks++;
        if (Aout !== 32'h0) begin
            failures++;
            $display("FAIL clr_vs_write got=%h exp=00000000", Aout);
        end
        rf_write(5'd5, 2'd0, 32'h6666_1111, 1'b0);
        set_read(5'd5, 5'd0, 2'd0);
        checks++;
        if (Aout !== 32'h6666_1111) begin
            failures++;
            $display("FAIL write_after_clr got=%h exp=66661111", Aout);
        end
    endtask

    task automatic test_trap_adder();
        logic [31:0] xs [3];
        logic        en [3];
        logic [31:0] ex [3];
        logic [31:0] e;
        xs = '{32'h0000_1230, 32'h0000_1230, 32'hFFFF_FFFC};
        en = '{1'b0, 1'b1, 1'b0};
        ex = '{32'h0000_1234, 32'h0000_1230, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            x = xs[i]; TB_ADD = en[i];
            #1;
            checks++;
            if (tb_out !== ex[i]) begin
                failures++;
                $display("FAIL trap_dir%0d got=%h exp=%h", i, tb_out, ex[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            TB_ADD = 1'($urandom);
            #1;
            e = TB_ADD ? x : 32'((longint'(x) + 4) % 64'h1_0000_0000);
            checks++;
            if (tb_out !== e) begin
                failures++;
                $display("FAIL trap_rand x=%h en_n=%b got=%h exp=%h", x, TB_ADD, tb_out, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_add();
        test_window();
        test_alu_directed();
        test_alu_random();
        test_rf_random();
        test_write_gating();
        test_trap_adder();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
